branch_predictor: RTL and testbench

- Fetch-side branch direction and target predictor, 2-bit counters plus a direct-mapped target buffer.
- Fetch looks up the current PC combinationally and gets a predicted next PC.
- The execute stage reports the resolved outcome (taken flag from branch control, target from the adder).
- The block trains its tables on that outcome and raises a registered mispredict/redirect to the front end one cycle later.

---
 rtl/branch_predictor.sv | 127 ++++++++++++
 tb/tb_branch_predictor.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Fetch-side direction/target predictor: 2-bit counters plus direct-mapped target buffer.
// Latency: lookup is combinational; training and mispredict/redirect are registered (1 cycle).
// Backpressure: none; one resolved branch accepted every cycle, lookup always answers.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int XLEN    = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [XLEN-1:0] i_pc,
    output logic            o_pred_taken,
    output logic [XLEN-1:0] o_pred_target,
    input  logic            i_up_valid,
    input  logic [XLEN-1:0] i_up_pc,
    input  logic            i_up_taken,
    input  logic [XLEN-1:0] i_up_target,
    input  logic            i_up_pred_taken,
    input  logic [XLEN-1:0] i_up_pred_target,
    output logic            o_mispredict,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic [31:0]     o_miss_count
);

    localparam int TAG_W = XLEN - IDX_W - 2;

    // Table storage: valid and counter are reset, tag and target are not
    logic             valid_q [ENTRIES];
    logic [1:0]       ctr_q   [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [XLEN-1:0]  tgt_q   [ENTRIES];

    logic [IDX_W-1:0] look_idx;
    logic [TAG_W-1:0] look_tag;
    logic             look_hit;
    logic [XLEN-1:0]  look_seq;

    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic [XLEN-1:0]  up_seq;
    logic [XLEN-1:0]  actual_pc;
    logic [XLEN-1:0]  predicted_pc;
    logic             miss_now;

    logic             mispredict_q;
    logic [XLEN-1:0]  redirect_q;
    logic [31:0]      miss_cnt;

    assign look_idx = i_pc[IDX_W+1:2];
    assign look_tag = i_pc[XLEN-1:IDX_W+2];
    assign look_seq = i_pc + XLEN'(4);

    assign up_idx   = i_up_pc[IDX_W+1:2];
    assign up_tag   = i_up_pc[XLEN-1:IDX_W+2];
    assign up_seq   = i_up_pc + XLEN'(4);

    // Fetch lookup reads registered state, so a same-cycle update is not yet visible
    always_comb begin
        look_hit      = valid_q[look_idx] && (tag_q[look_idx] == look_tag);
        o_pred_taken  = look_hit && ctr_q[look_idx][1];
        o_pred_target = o_pred_taken ? tgt_q[look_idx] : look_seq;
    end

    // Resolved-branch hit test and correct-vs-predicted next PC comparison
    always_comb begin
        up_hit       = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        actual_pc    = i_up_taken ? i_up_target : up_seq;
        predicted_pc = i_up_pred_taken ? i_up_pred_target : up_seq;
        miss_now     = i_up_valid && (actual_pc != predicted_pc);
    end

    // Valid bits and saturating counters; only taken branches allocate
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
            end
        end else if (i_up_valid) begin
            if (i_up_taken) begin
                if (up_hit) begin
                    if (ctr_q[up_idx] != 2'b11) begin
                        ctr_q[up_idx] <= ctr_q[up_idx] + 2'd1;
                    end
                end else begin
                    valid_q[up_idx] <= 1'b1;
                    ctr_q[up_idx]   <= 2'b10;
                end
            end else if (up_hit && (ctr_q[up_idx] != 2'b00)) begin
                ctr_q[up_idx] <= ctr_q[up_idx] - 2'd1;
            end
        end
    end

    // Tag and target payload; every taken resolution refreshes the target
    always_ff @(posedge i_clk) begin
        if (!i_rst && i_up_valid && i_up_taken) begin
            tgt_q[up_idx] <= i_up_target;
            if (!up_hit) begin
                tag_q[up_idx] <= up_tag;
            end
        end
    end

    // Registered mispredict pulse, sticky redirect PC and saturating miss counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mispredict_q <= 1'b0;
            redirect_q   <= '0;
            miss_cnt     <= '0;
        end else begin
            mispredict_q <= miss_now;
            if (miss_now) begin
                redirect_q <= actual_pc;
                if (miss_cnt != 32'hFFFF_FFFF) begin
                    miss_cnt <= miss_cnt + 32'd1;
                end
            end
        end
    end

    assign o_mispredict  = mispredict_q;
    assign o_redirect_pc = redirect_q;
    assign o_miss_count  = miss_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with hand-computed expectations.
// Latency: drives 1 time unit after each rising edge, samples in the same window.
// Backpressure: not applicable; each update occupies exactly one cycle.
module tb_branch_predictor;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [31:0] i_pc;
    logic        o_pred_taken;
    logic [31:0] o_pred_target;
    logic        i_up_valid;
    logic [31:0] i_up_pc;
    logic        i_up_taken;
    logic [31:0] i_up_target;
    logic        i_up_pred_taken;
    logic [31:0] i_up_pred_target;
    logic        o_mispredict;
    logic [31:0] o_redirect_pc;
    logic [31:0] o_miss_count;

    int n_checks = 0;
    int n_errors = 0;

    branch_predictor #(.ENTRIES(16), .IDX_W(4), .XLEN(32)) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_pc             (i_pc),
        .o_pred_taken     (o_pred_taken),
        .o_pred_target    (o_pred_target),
        .i_up_valid       (i_up_valid),
        .i_up_pc          (i_up_pc),
        .i_up_taken       (i_up_taken),
        .i_up_target      (i_up_target),
        .i_up_pred_taken  (i_up_pred_taken),
        .i_up_pred_target (i_up_pred_target),
        .o_mispredict     (o_mispredict),
        .o_redirect_pc    (o_redirect_pc),
        .o_miss_count     (o_miss_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    // Present one resolved branch for a single edge, then drop valid
    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                       input logic ptk, input logic [31:0] ptg);
        i_up_valid       = 1'b1;
        i_up_pc          = pc;
        i_up_taken       = tk;
        i_up_target      = tg;
        i_up_pred_taken  = ptk;
        i_up_pred_target = ptg;
        tick();
        i_up_valid       = 1'b0;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic etk,
                        input logic [31:0] etg);
        i_pc = pc;
        #1;
        check({tag, "_taken"}, {31'd0, o_pred_taken}, {31'd0, etk});
        check({tag, "_target"}, o_pred_target, etg);
    endtask

    task automatic mp(input string tag, input logic em, input logic [31:0] ecnt);
        check({tag, "_mispredict"}, {31'd0, o_mispredict}, {31'd0, em});
        check({tag, "_count"}, o_miss_count, ecnt);
    endtask

    initial begin
        i_rst = 1'b1; i_pc = 32'h100; i_up_valid = 1'b0; i_up_pc = '0; i_up_taken = 1'b0;
        i_up_target = '0; i_up_pred_taken = 1'b0; i_up_pred_target = '0;
        tick(); tick();
        i_rst = 1'b0;

        // Reset state
        look("rst_look", 32'h100, 1'b0, 32'h104);
        mp("rst", 1'b0, 32'd0);
        check("rst_redirect", o_redirect_pc, 32'h0);

        // First taken at 0x100 allocates with ctr=10 and mispredicts
        upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        mp("alloc", 1'b1, 32'd1);
        check("alloc_redirect", o_redirect_pc, 32'h80);
        look("alloc_look", 32'h100, 1'b1, 32'h80);
        tick();
        mp("idle_pulse_end", 1'b0, 32'd1);

        // Three correctly predicted takens: ctr 10 -> 11 -> 11 -> 11
        for (int k = 0; k < 3; k++) begin
            upd(32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
            mp($sformatf("sat_up%0d", k), 1'b0, 32'd1);
        end
        check("redirect_hold", o_redirect_pc, 32'h80);

        // Two not-taken predicted taken: back-to-back pulses, ctr 11 -> 10 -> 01
        upd(32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        mp("nt1", 1'b1, 32'd2);
        check("nt1_redirect", o_redirect_pc, 32'h104);
        look("nt1_look", 32'h100, 1'b1, 32'h80);
        upd(32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        mp("nt2", 1'b1, 32'd3);
        look("nt2_look", 32'h100, 1'b0, 32'h104);

        // Two more not-taken correctly predicted: ctr 01 -> 00 -> 00
        upd(32'h100, 1'b0, 32'h80, 1'b0, 32'h104);
        mp("nt3", 1'b0, 32'd3);
        upd(32'h100, 1'b0, 32'h80, 1'b0, 32'h104);
        mp("nt4", 1'b0, 32'd3);

        // Underflow guard: one taken lifts 00 to 01 (still not-taken), next to 10
        upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        mp("floor_t1", 1'b1, 32'd4);
        look("floor_t1_look", 32'h100, 1'b0, 32'h104);
        upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        mp("floor_t2", 1'b1, 32'd5);
        look("floor_t2_look", 32'h100, 1'b1, 32'h80);

        // Aliasing: 0x140 shares index 0 with a different tag and evicts 0x100
        upd(32'h140, 1'b1, 32'h200, 1'b0, 32'h144);
        mp("alias", 1'b1, 32'd6);
        check("alias_redirect", o_redirect_pc, 32'h200);
        look("alias_old", 32'h100, 1'b0, 32'h104);
        look("alias_new", 32'h140, 1'b1, 32'h200);
        look("other_idx", 32'h104, 1'b0, 32'h108);

        // Same-cycle lookup/update with right direction but wrong target
        i_pc             = 32'h140;
        i_up_valid       = 1'b1;
        i_up_pc          = 32'h140;
        i_up_taken       = 1'b1;
        i_up_target      = 32'h300;
        i_up_pred_taken  = 1'b1;
        i_up_pred_target = 32'h200;
        look("rbw_before", 32'h140, 1'b1, 32'h200);
        tick();
        i_up_valid = 1'b0;
        mp("wrong_tgt", 1'b1, 32'd7);
        check("wrong_tgt_redirect", o_redirect_pc, 32'h300);
        look("rbw_after", 32'h140, 1'b1, 32'h300);

        // Sequential next PC wraps at the top of the address space
        look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

        // Mismatching but invalid update is ignored
        i_up_pc = 32'h180; i_up_taken = 1'b1; i_up_target = 32'h40;
        i_up_pred_taken = 1'b0; i_up_pred_target = 32'h184;
        tick();
        mp("invalid", 1'b0, 32'd7);
        check("invalid_redirect", o_redirect_pc, 32'h300);
        look("invalid_look", 32'h180, 1'b0, 32'h184);

        // Miss counter saturation via a preload just below the ceiling
        @(negedge i_clk);
        force dut.miss_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.miss_cnt;
        @(posedge i_clk);
        #1;
        upd(32'h1C0, 1'b1, 32'h40, 1'b0, 32'h1C4);
        mp("sat1", 1'b1, 32'hFFFF_FFFF);
        upd(32'h1C0, 1'b0, 32'h40, 1'b1, 32'h40);
        mp("sat2", 1'b1, 32'hFFFF_FFFF);

        // Reset wins over a simultaneous mispredicting update
        i_rst = 1'b1;
        upd(32'h180, 1'b1, 32'h40, 1'b0, 32'h184);
        i_rst = 1'b0;
        mp("rst_upd", 1'b0, 32'd0);
        check("rst_upd_redirect", o_redirect_pc, 32'h0);
        look("rst_upd_140", 32'h140, 1'b0, 32'h144);
        look("rst_upd_180", 32'h180, 1'b0, 32'h184);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
